// File: rtl/tff_updown_counter_pkg.sv
// Shared definitions for the T flip-flop based up/down counter family:
// direction encodings and the elaboration-time modulus limit helper.
package tff_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Largest modulus a counter of the given width can represent (2^width).
    function automatic int max_mod(input int width);
        return 1 << width;
    endfunction

endpackage

// File: rtl/tff_cell.sv
// Single toggle flip-flop: flips its output on a rising clock edge whenever
// the toggle input is high, cleared asynchronously by an active-high reset.
module tff_cell (
    input  logic ck,
    input  logic rs,
    input  logic t,
    output logic q
);

    // Toggle storage with asynchronous clear
    always_ff @(posedge ck or posedge rs) begin
        if (rs) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/tff_updown_counter.sv
// Modulo-MOD up/down counter built from WIDTH toggle cells. The next count is
// computed from the clear/load/count priority rules, and each cell is told to
// toggle exactly where the current and next counts differ. A combinational
// terminal count lets several stages be chained on the same clock edge.
module tff_updown_counter
    import tff_counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MOD   = 16
) (
    input  logic             ck,
    input  logic             rs,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    // Largest legal count, in the widened arithmetic width and in the
    // register width. Widening keeps MOD = 2^WIDTH free of overflow.
    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MOD - 1);
    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MOD - 1);

    if ((WIDTH < 1) || (WIDTH > 16)) begin : g_bad_width
        $error("tff_updown_counter: WIDTH must lie in 1..16");
    end
    if ((MOD < 2) || (MOD > max_mod(WIDTH))) begin : g_bad_mod
        $error("tff_updown_counter: MOD must lie in 2..2^WIDTH");
    end

    logic [WIDTH:0]   q_ext;
    logic [WIDTH:0]   d_ext;
    logic [WIDTH:0]   next_ext;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] t;
    logic             ovf_q;
    logic             ovf_d;
    logic             unusedTop;

    assign q_ext = {1'b0, q};
    assign d_ext = {1'b0, d};

    // Next count and overflow flag from the clear > load > count > hold rules
    always_comb begin
        next_ext = q_ext;
        ovf_d    = ovf_q;
        if (clr) begin
            next_ext = '0;
            ovf_d    = 1'b0;
        end else if (ld) begin
            next_ext = (d_ext > MAX_EXT) ? MAX_EXT : d_ext;
        end else if (en) begin
            if (up == DIR_UP) begin
                if (q_ext == MAX_EXT) begin
                    next_ext = '0;
                    ovf_d    = 1'b1;
                end else begin
                    next_ext = q_ext + (WIDTH+1)'(1);
                end
            end else begin
                if (q_ext == '0) begin
                    next_ext = MAX_EXT;
                    ovf_d    = 1'b1;
                end else begin
                    next_ext = q_ext - (WIDTH+1)'(1);
                end
            end
        end
    end

    // The count never reaches MOD, so the extra arithmetic bit is always zero.
    assign q_next    = next_ext[WIDTH-1:0];
    assign unusedTop = next_ext[WIDTH];

    // A cell toggles wherever the next count differs from the current one.
    assign t = q ^ q_next;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .ck (ck),
            .rs (rs),
            .t  (t[i]),
            .q  (q[i])
        );
    end

    // Sticky wrap flag register
    always_ff @(posedge ck or posedge rs) begin
        if (rs) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;

    // Terminal count: high only in a cycle whose edge will wrap the counter.
    assign tc = en & ((up == DIR_DOWN) ? (q == '0) : (q == MAX_Q));

endmodule

// File: tb/tb_tff_updown_counter.sv
// Bench for tff_updown_counter: three instances (4-bit mod 16, 4-bit mod 10,
// 3-bit mod 8) share one input set and are compared against an arithmetic
// reference model; a two-stage mod-10 cascade is checked as a 00..99 counter.
module tb_tff_updown_counter;

    logic       ck;
    logic       rs;
    logic       en, up, clr, ld;
    logic [3:0] d;

    logic [3:0] qA, qB;
    logic [2:0] qC;
    logic       tcA, tcB, tcC;
    logic       ovfA, ovfB, ovfC;

    logic       enK, upK, clrK, ldK;
    logic [3:0] dK;
    logic [3:0] qLo, qHi;
    logic       tcLo, tcHi, ovfLo, ovfHi;

    int checks = 0;
    int errors = 0;

    int mA, mB, mC;
    bit oA, oB, oC;
    int pair;

    tff_updown_counter #(.WIDTH(4), .MOD(16)) dutA (
        .ck(ck), .rs(rs), .en(en), .up(up), .clr(clr), .ld(ld), .d(d),
        .q(qA), .tc(tcA), .ovf(ovfA));

    tff_updown_counter #(.WIDTH(4), .MOD(10)) dutB (
        .ck(ck), .rs(rs), .en(en), .up(up), .clr(clr), .ld(ld), .d(d),
        .q(qB), .tc(tcB), .ovf(ovfB));

    tff_updown_counter #(.WIDTH(3), .MOD(8)) dutC (
        .ck(ck), .rs(rs), .en(en), .up(up), .clr(clr), .ld(ld), .d(d[2:0]),
        .q(qC), .tc(tcC), .ovf(ovfC));

    tff_updown_counter #(.WIDTH(4), .MOD(10)) dutLo (
        .ck(ck), .rs(rs), .en(enK), .up(upK), .clr(clrK), .ld(ldK), .d(dK),
        .q(qLo), .tc(tcLo), .ovf(ovfLo));

    tff_updown_counter #(.WIDTH(4), .MOD(10)) dutHi (
        .ck(ck), .rs(rs), .en(tcLo), .up(upK), .clr(clrK), .ld(ldK), .d(dK),
        .q(qHi), .tc(tcHi), .ovf(ovfHi));

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    // Reference count after one edge, from modular arithmetic
    function automatic int nextCount(input int modv, input bit c, input bit l,
                                     input bit e, input bit u, input int dv,
                                     input int m);
        if (c) return 0;
        if (l) return (dv < modv) ? dv : modv - 1;
        if (e) return u ? (m + 1) % modv : (m + modv - 1) % modv;
        return m;
    endfunction

    // Reference sticky flag after one edge
    function automatic bit nextWrap(input int modv, input bit c, input bit l,
                                    input bit e, input bit u, input int m,
                                    input bit o);
        if (c) return 1'b0;
        if (l) return o;
        if (e && (u ? (m + 1 == modv) : (m == 0))) return 1'b1;
        return o;
    endfunction

    function automatic bit tcModel(input int modv, input bit e, input bit u,
                                   input int m);
        return e && (u ? (m == modv - 1) : (m == 0));
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string phase);
        checkOutput({phase, ":qA"},   qA,   mA);
        checkOutput({phase, ":ovfA"}, ovfA, oA);
        checkOutput({phase, ":qB"},   qB,   mB);
        checkOutput({phase, ":ovfB"}, ovfB, oB);
        checkOutput({phase, ":qC"},   qC,   mC);
        checkOutput({phase, ":ovfC"}, ovfC, oC);
    endtask

    // Drive one cycle of inputs, check tc before the edge, then q/ovf after it
    task automatic applyStimulus(input string phase, input bit c, input bit l,
                                 input bit e, input bit u, input logic [3:0] dv);
        clr = c; ld = l; en = e; up = u; d = dv;
        #1;
        checkOutput({phase, ":tcA"}, tcA, tcModel(16, e, u, mA));
        checkOutput({phase, ":tcB"}, tcB, tcModel(10, e, u, mB));
        checkOutput({phase, ":tcC"}, tcC, tcModel(8,  e, u, mC));
        @(posedge ck); #1;
        oA = nextWrap(16, c, l, e, u, mA, oA);
        mA = nextCount(16, c, l, e, u, int'(dv), mA);
        oB = nextWrap(10, c, l, e, u, mB, oB);
        mB = nextCount(10, c, l, e, u, int'(dv), mB);
        oC = nextWrap(8, c, l, e, u, mC, oC);
        mC = nextCount(8, c, l, e, u, int'(dv[2:0]), mC);
        checkAll(phase);
    endtask

    initial begin
        rs = 1'b1;
        en = 1'b0; up = 1'b0; clr = 1'b0; ld = 1'b0; d = 4'd0;
        enK = 1'b0; upK = 1'b1; clrK = 1'b0; ldK = 1'b0; dK = 4'd0;
        mA = 0; mB = 0; mC = 0; oA = 0; oB = 0; oC = 0;

        // Power-on reset state
        #12;
        checkAll("reset");
        checkOutput("reset:tcB", tcB, 1'b0);
        rs = 1'b0;
        @(posedge ck); #1;
        $display("[TB] reset released");

        // Up wrap: 12 edges from zero
        for (int i = 0; i < 12; i++) applyStimulus("upWrap", 0, 0, 1, 1, 4'd0);
        checkOutput("upWrap:finalQB", qB, 4'd2);
        checkOutput("upWrap:finalOvfB", ovfB, 1'b1);

        // Down wrap: clear, load 1, then three down edges
        applyStimulus("downPrep", 1, 0, 0, 0, 4'd0);
        applyStimulus("downPrep", 0, 1, 0, 0, 4'd1);
        for (int i = 0; i < 3; i++) applyStimulus("downWrap", 0, 0, 1, 0, 4'd0);
        checkOutput("downWrap:finalQB", qB, 4'd8);

        // Load saturation and input priority
        applyStimulus("ldSat", 0, 1, 0, 1, 4'd13);
        checkOutput("ldSat:qB", qB, 4'd9);
        applyStimulus("ldBeatsEn", 0, 1, 1, 1, 4'd5);
        checkOutput("ldBeatsEn:qB", qB, 4'd5);
        applyStimulus("clrWins", 1, 1, 1, 1, 4'd7);
        checkOutput("clrWins:ovfB", ovfB, 1'b0);

        // Full-range binary count on the 3-bit mod-8 instance
        for (int i = 0; i < 8; i++) applyStimulus("fullRange", 0, 0, 1, 1, 4'd0);
        checkOutput("fullRange:qC", qC, 3'd0);
        checkOutput("fullRange:ovfC", ovfC, 1'b1);

        // Reset mid-count: load 9, pulse reset between edges
        applyStimulus("midLoad", 0, 1, 0, 1, 4'd9);
        rs = 1'b1;
        #2;
        checkOutput("midRst:qA", qA, 4'd0);
        checkOutput("midRst:ovfC", ovfC, 1'b0);
        mA = 0; mB = 0; mC = 0; oA = 0; oB = 0; oC = 0;
        checkAll("midRst");
        rs = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus("resume", 0, 0, 1, 1, 4'd0);
        checkOutput("resume:qA", qA, 4'd3);

        // Randomised traffic against the reference model
        for (int i = 0; i < 300; i++) begin
            applyStimulus("random",
                          ($urandom_range(0, 15) == 0),
                          ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 1)),
                          4'($urandom_range(0, 15)));
        end
        clr = 1'b0; ld = 1'b0; en = 1'b0; up = 1'b0; d = 4'd0;

        // Two-stage decimal cascade: 100 edges from 00
        clrK = 1'b1;
        @(posedge ck); #1;
        clrK = 1'b0;
        pair = 0;
        checkOutput("cascade:startLo", qLo, 4'd0);
        checkOutput("cascade:startHi", qHi, 4'd0);
        enK = 1'b1;
        for (int k = 0; k < 100; k++) begin
            #1;
            checkOutput("cascade:tcHi", tcHi, (pair == 99));
            @(posedge ck); #1;
            pair = (pair + 1) % 100;
            checkOutput("cascade:lo", qLo, pair % 10);
            checkOutput("cascade:hi", qHi, pair / 10);
            checkOutput("cascade:ovfHi", ovfHi, (k == 99));
        end
        enK = 1'b0;
        checkOutput("cascade:endLo", qLo, 4'd0);
        checkOutput("cascade:endHi", qHi, 4'd0);
        checkOutput("cascade:endOvfLo", ovfLo, 1'b1);
        checkOutput("cascade:endOvfHi", ovfHi, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tff_updown_counter.md
# tff_updown_counter

Parametrised modulo-N up/down counter built from toggle flip-flop cells, succeeding the fixed 4-bit up-only T-FF counter used in the lab designs. Adds programmable width and modulus, a direction control, a synchronous load and clear, a cascadable terminal-count output and a sticky overflow flag. It sits directly behind the switch/button inputs and drives LED or 7-segment display logic. It can be chained with further instances through `tc`.

## Interface
Parameters:
- `WIDTH`, 4, counter width in bits; legal range 1..16.
- `MOD`, 16, count modulus; legal range 2..2^WIDTH; states 0..MOD-1.

Ports:
- `ck`  in  1  clock; all state changes on rising edge.
- `rs`  in  1  reset, asynchronous, active-high.
- `en`  in  1  count enable.
- `up`  in  1  direction; 1 = increment, 0 = decrement.
- `clr` in  1  synchronous clear.
- `ld`  in  1  synchronous load.
- `d`   in  WIDTH  load value.
- `q`   out WIDTH  count value.
- `tc`  out 1  terminal count, combinational; feeds the next stage's `en`.
- `ovf` out 1  sticky wrap flag.

## Operation
- Reset: `rs`=1 forces `q`=0 and `ovf`=0 immediately, independent of `ck`. `tc` then follows its equation.
- Per-edge priority when `rs`=0: `clr` > `ld` > `en` > hold.
  - `clr`=1: `q`←0, `ovf`←0.
  - `ld`=1: `q`←`d` if `d` ≤ MOD-1, else `q`←MOD-1 (saturate). `ovf` is unchanged.
  - `en`=1, `up`=1: `q`←`q`+1. If `q`=MOD-1, `q`←0 and `ovf`←1.
  - `en`=1, `up`=0: `q`←`q`-1. If `q`=0, `q`←MOD-1 and `ovf`←1.
  - Otherwise `q` and `ovf` hold.
- `tc` = `en` & (`up` ? `q`==MOD-1 : `q`==0). It is asserted only in the cycle whose edge wraps the counter.
- `up` may change every cycle. Direction is sampled on the same edge as `en`.
- `q` must never hold a value ≥ MOD, including after `ld`.
- Arithmetic is done in WIDTH+1 bits internally so that MOD = 2^WIDTH produces no intermediate overflow. The wrap compare uses the constant MOD-1.

## Timing
- Latency: `en`, `ld` and `clr` take effect on `q` at the first rising edge where they are sampled high. `q` is registered.
- `tc` has zero latency from `q`, `en` and `up`. It has no registered delay, so cascaded stages advance on the same edge.
- `ovf` sets on the wrapping edge, together with the `q` transition.
- `rs` asserted mid-count clears outputs asynchronously.
- On `rs` deassertion, the first count happens at the first rising edge with `rs`=0 and `en`=1.
- Simultaneous `clr`, `ld` and `en`: only `clr` acts.
- Simultaneous `ld` and `en`: the load wins and no count occurs. `tc` may still read 1 in that cycle. The cascade user must gate on `ld`.

## Structure
- Shared package `tff_counter_pkg`:
  - direction constants `DIR_UP`=1'b1, `DIR_DOWN`=1'b0;
  - function `max_mod(WIDTH)` returning 2^WIDTH, used for elaboration-time parameter range checks.
- Sub-module `tff_cell`: a single T flip-flop.
  - Ports: `ck`, `rs` (async active-high), `t`, `q`.
  - Toggles `q` on the rising edge when `t`=1.
- Top-level datapath:
  - Compute the next-state vector `q_next` from the priority rules.
  - Derive the toggle vector `t` = `q` ^ `q_next`.
  - Drive WIDTH `tff_cell` instances with `t`.
  - `ovf` is a plain register in the top level.

## Test plan
- Reset mid-count: with WIDTH=4, MOD=16 and `q`=9, pulse `rs` between edges → `q`=0 and `ovf`=0 immediately; with `en`=1 and `up`=1, counts resume 1, 2, … from the first edge after release.
- Up wrap: WIDTH=4, MOD=10, `en`=1, `up`=1 for 12 edges from 0 → `q` runs 1..9, 0, 1, 2; `tc`=1 only while `q`=9; `ovf`=1 from the 10th edge onward.
- Down wrap: WIDTH=4, MOD=10, start at 1 with `up`=0 for 3 edges → `q` = 0, 9, 8; `tc`=1 only while `q`=0; `ovf` sets on the 0→9 edge.
- Load saturation and priority:
  - `ld`=1 with `d`=13 at MOD=10 → `q`=9.
  - `ld`=1, `d`=5, `en`=1 on the same edge → `q`=5.
  - `clr`=1, `ld`=1, `en`=1 on the same edge → `q`=0 and `ovf`=0.
- Full-range binary: WIDTH=3, MOD=8, count up 8 edges from 0 → `q` returns to 0 with `ovf`=1; every `q` value matches a reference counter.
- Cascade: two instances with WIDTH=4 and MOD=10, the low stage's `tc` driving the high stage's `en`, 100 edges from 00 → the pair reads 99, then 00 with `ovf`=1 on both stages.
